// File: rtl/math_pkg.sv
// Shared math-cluster types and saturation limits for fixed-point datapaths.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package math_pkg;

    // Sequential divider control states
    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    // Largest representable value of a width-bit number (signed or unsigned)
    function automatic logic [63:0] sat_max(input int width, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) begin
            return (one << (width - 1)) - one;
        end
        return (one << width) - one;
    endfunction

    // Smallest representable value, as a width-bit two's-complement pattern
    function automatic logic [63:0] sat_min(input int width, input bit is_signed);
        logic [63:0] one;
        one = 64'd1;
        if (is_signed) begin
            return one << (width - 1);
        end
        return 64'd0;
    endfunction

endpackage

// File: rtl/fixed_sat.sv
// Applies the result sign to an unsigned magnitude and saturates it to WIDTH bits.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module fixed_sat
    import math_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int Q_BITS = 12,
    parameter int SIGNED = 1
) (
    input  logic [WIDTH+Q_BITS:0] mag,
    input  logic                  neg,
    output logic [WIDTH-1:0]      result,
    output logic                  overflow
);

    localparam int MW = WIDTH + Q_BITS + 1;
    localparam logic [63:0]      MAX64   = sat_max(WIDTH, SIGNED != 0);
    localparam logic [63:0]      MIN64   = sat_min(WIDTH, SIGNED != 0);
    localparam logic [WIDTH-1:0] MAXV    = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MINV    = MIN64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]    ONE_MW  = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0]    POS_LIM = {{(MW-WIDTH){1'b0}}, MAXV};
    // Negative results may reach one further than positive ones (-2^(WIDTH-1))
    localparam logic [MW-1:0]    NEG_LIM = POS_LIM + ONE_MW;

    // Clamp the magnitude against the limit for its sign, then negate if needed
    always_comb begin
        result   = mag[WIDTH-1:0];
        overflow = 1'b0;
        if ((SIGNED != 0) && neg) begin
            if (mag > NEG_LIM) begin
                result   = MINV;
                overflow = 1'b1;
            end else begin
                result = ~mag[WIDTH-1:0] + ONE_W;
            end
        end else if (mag > POS_LIM) begin
            result   = MAXV;
            overflow = 1'b1;
        end
    end

endmodule

// File: rtl/fixed_div_seq.sv
// Sequential radix-2 restoring fixed-point divider with tag passthrough and saturation.
// Latency: WIDTH+Q_BITS+1 cycles from accept to out_valid (2 cycles for divide-by-zero).
// Backpressure: one op in flight; in_ready only in IDLE, result held until out_ready.
// Optional: define FIXDIV_ROUND_EN for round-half-away-from-zero instead of truncation.
module fixed_div_seq
    import math_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int Q_BITS = 12,
    parameter int SIGNED = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic             overflow,
    output logic             div_by_zero,
    output logic [TAG_W-1:0] out_tag
);

    localparam int N  = WIDTH + Q_BITS;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]    N_CNT   = CW'(N);
    localparam logic [CW-1:0]    ONE_CNT = CW'(1);
    localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [63:0]      MAX64   = sat_max(WIDTH, SIGNED != 0);
    localparam logic [63:0]      MIN64   = sat_min(WIDTH, SIGNED != 0);
    localparam logic [WIDTH-1:0] MAXV    = MAX64[WIDTH-1:0];
    localparam logic [WIDTH-1:0] MINV    = MIN64[WIDTH-1:0];

    div_state_t       state, state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;       // partial remainder, always < divisor magnitude
    logic [WIDTH-1:0] dsr;       // divisor magnitude
    logic [N-1:0]     acc;       // dividend bits shift out the top, quotient bits in the bottom
    logic             res_neg;
    logic             dvd_neg;
    logic             dbz_pend;
    logic             fix_hold;  // divide-by-zero spends one extra cycle in FIX
    logic [TAG_W-1:0] tag_q;

    logic             fire;
    logic             dvd_sgn, dsr_sgn;
    logic [WIDTH-1:0] dvd_mag, dsr_mag;
    logic [WIDTH:0]   rem_sh;
    logic             can_sub;
    logic [WIDTH-1:0] rem_sub;
    logic [WIDTH-1:0] rem_next;
    logic [N:0]       q_mag;
    logic [WIDTH-1:0] sat_q;
    logic             sat_ovf;

    assign in_ready  = (state == DIV_IDLE);
    assign out_valid = (state == DIV_DONE);
    assign fire      = in_valid && in_ready;

    // Operand signs and magnitudes; a WIDTH-bit negate of -2^(WIDTH-1) read as unsigned is exact
    always_comb begin
        dvd_sgn = (SIGNED != 0) && dividend[WIDTH-1];
        dsr_sgn = (SIGNED != 0) && divisor[WIDTH-1];
        dvd_mag = dvd_sgn ? (~dividend + ONE_W) : dividend;
        dsr_mag = dsr_sgn ? (~divisor + ONE_W) : divisor;
    end

    // One restoring step: shift in next dividend bit, subtract when it fits
    always_comb begin
        rem_sh   = {rem, acc[N-1]};
        can_sub  = (rem_sh >= {1'b0, dsr});
        // true difference is below 2^WIDTH, so the low bits alone are exact
        rem_sub  = rem_sh[WIDTH-1:0] - dsr;
        rem_next = can_sub ? rem_sub : rem_sh[WIDTH-1:0];
    end

`ifdef FIXDIV_ROUND_EN
    logic round_up;
    // Round half away from zero on the magnitude; a carry may push it into saturation
    always_comb begin
        round_up = ({rem, 1'b0} >= {1'b0, dsr});
        q_mag    = {1'b0, acc} + {{N{1'b0}}, round_up};
    end
`else
    // Truncation toward zero: the raw magnitude goes straight to saturation
    always_comb begin
        q_mag = {1'b0, acc};
    end
`endif

    fixed_sat #(
        .WIDTH  (WIDTH),
        .Q_BITS (Q_BITS),
        .SIGNED (SIGNED)
    ) u_sat (
        .mag      (q_mag),
        .neg      (res_neg),
        .result   (sat_q),
        .overflow (sat_ovf)
    );

    // Control state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: IDLE -> CALC (or FIX on zero divisor) -> FIX -> DONE -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE: begin
                if (fire) begin
                    state_nxt = (divisor == '0) ? DIV_FIX : DIV_CALC;
                end
            end
            DIV_CALC: begin
                if (cnt == ONE_CNT) begin
                    state_nxt = DIV_FIX;
                end
            end
            DIV_FIX: begin
                if (!fix_hold) begin
                    state_nxt = DIV_DONE;
                end
            end
            DIV_DONE: begin
                if (out_ready) begin
                    state_nxt = DIV_IDLE;
                end
            end
            default: state_nxt = DIV_IDLE;
        endcase
    end

    // Datapath: latch operands on accept, iterate in CALC, register result in FIX
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt         <= '0;
            rem         <= '0;
            dsr         <= '0;
            acc         <= '0;
            res_neg     <= 1'b0;
            dvd_neg     <= 1'b0;
            dbz_pend    <= 1'b0;
            fix_hold    <= 1'b0;
            tag_q       <= '0;
            quotient    <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            out_tag     <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (fire) begin
                        tag_q    <= in_tag;
                        dvd_neg  <= dvd_sgn;
                        res_neg  <= dvd_sgn ^ dsr_sgn;
                        acc      <= N'(dvd_mag) << Q_BITS;
                        dsr      <= dsr_mag;
                        rem      <= '0;
                        cnt      <= N_CNT;
                        dbz_pend <= (divisor == '0);
                        fix_hold <= (divisor == '0);
                    end
                end
                DIV_CALC: begin
                    rem <= rem_next;
                    acc <= {acc[N-2:0], can_sub};
                    cnt <= cnt - ONE_CNT;
                end
                DIV_FIX: begin
                    if (fix_hold) begin
                        fix_hold <= 1'b0;
                    end else begin
                        out_tag     <= tag_q;
                        div_by_zero <= dbz_pend;
                        if (dbz_pend) begin
                            quotient <= dvd_neg ? MINV : MAXV;
                            overflow <= 1'b0;
                        end else begin
                            quotient <= sat_q;
                            overflow <= sat_ovf;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_div_seq.sv
// Randomized and directed bench for fixed_div_seq against an arithmetic reference model.
// Latency: checks first out_valid cycle of every result against the expected delay.
// Backpressure: randomizes out_ready and holds it low for a stretch to test result stability.
module tb_fixed_div_seq;

    localparam int WIDTH  = 16;
    localparam int Q_BITS = 12;
    localparam int SIGNED = 1;
    localparam int TAG_W  = 4;
    localparam int N      = WIDTH + Q_BITS;
`ifdef FIXDIV_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] dividend = '0;
    logic [WIDTH-1:0] divisor = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] quotient;
    logic             overflow;
    logic             div_by_zero;
    logic [TAG_W-1:0] out_tag;

    fixed_div_seq #(
        .WIDTH  (WIDTH),
        .Q_BITS (Q_BITS),
        .SIGNED (SIGNED),
        .TAG_W  (TAG_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .out_tag     (out_tag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] q;
        bit               ovf;
        bit               dbz;
    } res_t;

    typedef struct {
        res_t             r;
        logic [TAG_W-1:0] tag;
        int               acc;
        int               lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   passed = 0;
    bit   hold_low = 1'b0;
    bit   seen = 1'b0;

    // Spec test vectors: dividend, divisor, quotient, overflow, div-by-zero
    logic [15:0] ta  [12] = '{16'h3000, 16'hD000, 16'h3000, 16'hD000, 16'h8000, 16'h7000,
                              16'h9000, 16'h1000, 16'hF000, 16'h0000, 16'h2000, 16'h1000};
    logic [15:0] tb_ [12] = '{16'h2000, 16'h2000, 16'hE000, 16'hE000, 16'h1000, 16'h0100,
                              16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h3000, 16'h3000};
    logic [15:0] tq  [12] = '{16'h1800, 16'hE800, 16'hE800, 16'h1800, 16'h8000, 16'h7FFF,
                              16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF,
                              ROUND ? 16'h0AAB : 16'h0AAA, 16'h0555};
    bit          tov [12] = '{0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    bit          tdz [12] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0};
    logic [15:0] corner [4] = '{16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act == expv) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    // Exact rational result from plain integer arithmetic, then round/saturate rules
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        res_t   r;
        longint sa, sb, am, bm, num, m, rm, val, maxi, mini;
        sa   = (SIGNED != 0) ? longint'($signed(a)) : longint'(a);
        sb   = (SIGNED != 0) ? longint'($signed(b)) : longint'(b);
        maxi = (SIGNED != 0) ? (longint'(1) << (WIDTH - 1)) - 1 : (longint'(1) << WIDTH) - 1;
        mini = (SIGNED != 0) ? -(longint'(1) << (WIDTH - 1)) : 0;
        r.ovf = 1'b0;
        r.dbz = 1'b0;
        if (sb == 0) begin
            r.dbz = 1'b1;
            val   = (sa < 0) ? mini : maxi;
        end else begin
            am  = (sa < 0) ? -sa : sa;
            bm  = (sb < 0) ? -sb : sb;
            num = am * (longint'(1) << Q_BITS);
            m   = num / bm;
            rm  = num % bm;
            if (ROUND && (2 * rm >= bm)) m++;
            val = ((sa < 0) != (sb < 0)) ? -m : m;
            if (val > maxi) begin
                val   = maxi;
                r.ovf = 1'b1;
            end else if (val < mini) begin
                val   = mini;
                r.ovf = 1'b1;
            end
        end
        r.q = val[WIDTH-1:0];
        return r;
    endfunction

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [TAG_W-1:0] tag);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("issue_wait_in_ready", in_ready, 1);
            return;
        end
        dividend = a;
        divisor  = b;
        in_tag   = tag;
        in_valid = 1'b1;
        e.r   = model(a, b);
        e.tag = tag;
        e.acc = cyc + 1;
        e.lat = e.r.dbz ? 2 : N + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", exp_q.size(), 0);
    endtask

    // Consumer: random out_ready unless a stall stretch is requested
    initial begin
        forever begin
            @(posedge clk);
            #1 out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Compare every cycle a result is presented against the head of the expectation queue
    initial begin
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                seen = 1'b0;
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", out_valid, 0);
                end else begin
                    cur = exp_q[0];
                    if (!seen) begin
                        chk("latency", cyc - cur.acc, cur.lat);
                        seen = 1'b1;
                    end
                    chk("quotient", quotient, cur.r.q);
                    chk("overflow", overflow, cur.r.ovf);
                    chk("div_by_zero", div_by_zero, cur.r.dbz);
                    chk("out_tag", out_tag, cur.tag);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        seen = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        res_t        r;
        logic [15:0] a, b;
        int          n;

        // Reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_tag", out_tag, 0);
        reset_n = 1'b1;

        // Pin the model to hand-computed spec results
        for (int i = 0; i < 12; i++) begin
            r = model(ta[i], tb_[i]);
            chk($sformatf("model_q_%0d", i), r.q, tq[i]);
            chk($sformatf("model_ovf_%0d", i), r.ovf, tov[i]);
            chk($sformatf("model_dbz_%0d", i), r.dbz, tdz[i]);
        end

        // Same vectors through the DUT
        for (int i = 0; i < 12; i++) begin
            issue(ta[i], tb_[i], TAG_W'(i));
        end
        wait_idle();

        // Stall the consumer: result held, new requests ignored
        hold_low = 1'b1;
        @(negedge clk);
        issue(16'h5000, 16'h2000, 4'hA);
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("hold_out_valid", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_tag", out_tag, 4'hA);
            chk("hold_out_valid_kept", out_valid, 1);
            dividend = 16'($urandom);
            divisor  = 16'h0001;
            in_tag   = 4'h5;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        hold_low = 1'b0;
        wait_idle();

        // Reset in the middle of CALC aborts the op
        issue(16'h3000, 16'h2000, 4'h3);
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        exp_q.delete();
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_quotient", quotient, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_dbz", div_by_zero, 0);
        chk("midrst_tag", out_tag, 0);
        reset_n = 1'b1;
        issue(16'h3000, 16'h2000, 4'h6);
        wait_idle();

        // Randomized operands with corner values and zero/small divisors mixed in
        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a = corner[$urandom_range(0, 3)];
            case ($urandom_range(0, 7))
                0:       b = 16'h0000;
                1, 2: begin
                    b = 16'($urandom_range(1, 255));
                    if ($urandom_range(0, 1) == 1) b = ~b + 16'h0001;
                end
                default: b = 16'($urandom);
            endcase
            issue(a, b, 4'($urandom));
        end
        wait_idle();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
